// File: rtl/la_seq_capture.sv
// -----------------------------------------------------------------------------
// la_seq_capture
//   Logic-analyzer capture core. Samples a WIDTH-bit bus every clock into a
//   circular buffer, keeps PRE samples of pre-trigger history, fires on a
//   STAGES-long masked sequence over consecutive samples, captures the rest
//   of the window, then freezes the buffer for readout as 32-bit words.
//
// Ports
//   clk           sample/system clock, rising edge
//   _rst          asynchronous active-low reset
//   i_data        bus under test
//   i_btn         arm request (level; rising edge arms)
//   i_stage_val   per-stage match value, stage k at [k*WIDTH +: WIDTH]
//   i_stage_mask  per-stage care mask, 1 = compare the bit
//   i_read        one-cycle read strobe, advances to the next word
//   o_run         capture in progress
//   o_available   buffer frozen, o_data valid
//   o_triggered   one-cycle pulse after the sequence completes
//   o_data        {pre_flag, 0.., index, sample}
//
// Build option
//   LA_AUTO_REARM_EN  when defined, reading the last word restarts FILL
//                     instead of returning to IDLE.
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | nothing written, waiting for an arm edge
//   ST_FILL  | writing the PRE pre-trigger samples, matcher held at stage 0
//   ST_ARMED | writing continuously, sequence matcher running
//   ST_POST  | writing the DEPTH-PRE-1 post-trigger samples
//   ST_DONE  | buffer frozen, host reads words 0..DEPTH-1
// -----------------------------------------------------------------------------
module la_seq_capture #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int PRE    = 4,
    parameter int STAGES = 3
) (
    input  logic                      clk,
    input  logic                      _rst,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_btn,
    input  logic [STAGES*WIDTH-1:0]   i_stage_val,
    input  logic [STAGES*WIDTH-1:0]   i_stage_mask,
    input  logic                      i_read,
    output logic                      o_run,
    output logic                      o_available,
    output logic                      o_triggered,
    output logic [31:0]               o_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [AW-1:0] FILL_LOAD = AW'(PRE - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(DEPTH - PRE - 2);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_IDX   = AW'(PRE);
    localparam logic [SW-1:0] LAST_STG  = SW'(STAGES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stg_q, stg_d;
    logic              btn_q;
    logic              trig_q, trig_d;
    logic              wr_en;
    logic              arm;
    logic [STAGES-1:0] stage_hit;
    logic              cur_hit;
    logic [AW-1:0]     rd_addr;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    assign arm = i_btn & ~btn_q;

    // Don't-care bits are removed by the mask after the XOR.
    always_comb begin
        stage_hit = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_hit[k] = ((i_data ^ i_stage_val[k*WIDTH +: WIDTH])
                            & i_stage_mask[k*WIDTH +: WIDTH]) == '0;
        end
    end

    // Hit of the stage the matcher is currently waiting for.
    always_comb begin
        cur_hit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (stg_q == SW'(k)) begin
                cur_hit = stage_hit[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        trig_d  = 1'b0;
        wr_en   = 1'b0;

        if (arm) begin
            // Arming from any state restarts the capture; the buffer
            // contents are left alone and simply overwritten.
            state_d = ST_FILL;
            wp_d    = '0;
            rd_d    = '0;
            cnt_d   = FILL_LOAD;
            stg_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end

                ST_FILL: begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + AW'(1);
                    stg_d = '0;
                    if (cnt_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        cnt_d = cnt_q - AW'(1);
                    end
                end

                ST_ARMED: begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + AW'(1);
                    if (cur_hit) begin
                        if (stg_q == LAST_STG) begin
                            trig_d  = 1'b1;
                            stg_d   = '0;
                            cnt_d   = POST_LOAD;
                            state_d = ST_POST;
                        end else begin
                            stg_d = stg_q + SW'(1);
                        end
                    end else begin
                        // Only a one-step restart: no deeper backtracking.
                        stg_d = stage_hit[0] ? SW'(1) : '0;
                    end
                end

                ST_POST: begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + AW'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - AW'(1);
                    end
                end

                ST_DONE: begin
                    if (i_read) begin
                        if (rd_q == LAST_IDX) begin
                            rd_d = '0;
`ifdef LA_AUTO_REARM_EN
                            state_d = ST_FILL;
                            wp_d    = '0;
                            cnt_d   = FILL_LOAD;
                            stg_d   = '0;
`else
                            state_d = ST_IDLE;
`endif
                        end else begin
                            rd_d = rd_q + AW'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            stg_q   <= '0;
            btn_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            btn_q   <= i_btn;
            trig_q  <= trig_d;
        end
    end

    // Sample storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp_q] <= i_data;
        end
    end

    assign o_run       = (state_q == ST_FILL) || (state_q == ST_ARMED) ||
                         (state_q == ST_POST);
    assign o_available = (state_q == ST_DONE);
    assign o_triggered = trig_q;

    // After the freeze the write pointer addresses the oldest sample, so the
    // read index is an offset from it (wrapping modulo DEPTH).
    always_comb begin
        rd_addr = wp_q + rd_q;
        o_data  = '0;
        if (state_q == ST_DONE) begin
            o_data[WIDTH-1:0]        = mem_q[rd_addr];
            o_data[WIDTH+AW-1:WIDTH] = rd_q;
            o_data[31]               = (rd_q == PRE_IDX);
        end
    end

endmodule

// File: tb/tb_la_seq_capture.sv
module tb_la_seq_capture;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int PRE    = 4;
    localparam int STAGES = 3;

`ifdef LA_AUTO_REARM_EN
    localparam logic REARM = 1'b1;
`else
    localparam logic REARM = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    _rst = 1'b0;
    logic [WIDTH-1:0]        i_data = '0;
    logic                    i_btn = 1'b0;
    logic [STAGES*WIDTH-1:0] i_stage_val = '0;
    logic [STAGES*WIDTH-1:0] i_stage_mask = '0;
    logic                    i_read = 1'b0;
    logic                    o_run;
    logic                    o_available;
    logic                    o_triggered;
    logic [31:0]             o_data;

    always #5 clk = ~clk;

    la_seq_capture #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PRE   (PRE),
        .STAGES(STAGES)
    ) dut (
        .clk         (clk),
        ._rst        (_rst),
        .i_data      (i_data),
        .i_btn       (i_btn),
        .i_stage_val (i_stage_val),
        .i_stage_mask(i_stage_mask),
        .i_read      (i_read),
        .o_run       (o_run),
        .o_available (o_available),
        .o_triggered (o_triggered),
        .o_data      (o_data)
    );

    typedef struct {
        logic       btn;
        logic [7:0] data;
        logic       run;
        logic       trig;
        logic       avail;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] main_d [20];
    logic [7:0] exp_s  [16];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state for the randomized runs
    logic [7:0] mv [STAGES];
    logic [7:0] mm [STAGES];
    logic [7:0] wr[$];
    int         phase;
    int         pcnt;
    int         s;
    bit         trig_now;
    logic [7:0] d;
    int         idx;
    int         guard;
    bit         rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic b, input logic [7:0] dd, input logic er,
                       input logic et, input logic ea, input string nm);
        i_btn  = b;
        i_data = dd;
        tick();
        chk({nm, " run"},   32'(o_run),       32'(er));
        chk({nm, " trig"},  32'(o_triggered), 32'(et));
        chk({nm, " avail"}, 32'(o_available), 32'(ea));
    endtask

    task automatic set_stages(input logic [7:0] v0, v1, v2, m0, m1, m2);
        i_stage_val  = {v2, v1, v0};
        i_stage_mask = {m2, m1, m0};
    endtask

    function automatic logic [31:0] word(input int i, input logic [7:0] smp);
        logic [31:0] w;
        w = 32'(smp) | (32'(i) << WIDTH);
        if (i == PRE) w[31] = 1'b1;
        return w;
    endfunction

    function automatic bit hit(input logic [7:0] x, input int k);
        return ((x ^ mv[k]) & mm[k]) == 8'h00;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        main_d = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd5, 8'd4, 8'd5,
                   8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
                   8'd18, 8'd19, 8'd20, 8'd0};
        exp_s  = '{8'd3, 8'd7, 8'd5, 8'd4, 8'd5, 8'd10, 8'd11, 8'd12,
                   8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20};
        // btn held high for all 20 rows: must arm exactly once
        for (int i = 0; i < 20; i++) begin
            tbl.push_back('{1'b1, main_d[i], (i <= 17), (i == 7), (i >= 18)});
        end

        // ---- reset state
        #12;
        chk("rst run",   32'(o_run),       32'd0);
        chk("rst avail", 32'(o_available), 32'd0);
        chk("rst trig",  32'(o_triggered), 32'd0);
        chk("rst data",  o_data,           32'd0);
        _rst = 1'b1;
        tick();

        // ---- main capture, table driven
        set_stages(8'd5, 8'd4, 8'd5, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].btn, tbl[i].data, tbl[i].run, tbl[i].trig, tbl[i].avail,
                $sformatf("main[%0d]", i));
        end
        i_btn = 1'b0;

        // ---- back-to-back readout
        i_read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("main rd avail %0d", i), 32'(o_available), 32'd1);
            chk($sformatf("main rd word %0d", i), o_data, word(i, exp_s[i]));
            tick();
        end
        chk("main rd end avail", 32'(o_available), 32'd0);
        chk("main rd end data",  o_data,           32'd0);
        chk("main rd end run",   32'(o_run),       32'(REARM));
        i_read = 1'b0;

        // ---- restart rule, partial sequence, masked stage
        set_stages(8'd5, 8'd4, 8'd5, 8'hFF, 8'h0F, 8'hFF);
        cyc(1, 8'd0, 1, 0, 0, "seq arm");
        for (int i = 0; i < PRE; i++) cyc(0, 8'd0, 1, 0, 0, "seq fill");
        cyc(0, 8'd5,  1, 0, 0, "seq 5");
        cyc(0, 8'd4,  1, 0, 0, "seq 54");
        cyc(0, 8'd1,  1, 0, 0, "seq 541");
        cyc(0, 8'd9,  1, 0, 0, "seq 9");
        cyc(0, 8'd5,  1, 0, 0, "seq r5");
        cyc(0, 8'd5,  1, 0, 0, "seq r55");
        cyc(0, 8'hF4, 1, 0, 0, "seq r55F4");
        cyc(0, 8'd5,  1, 1, 0, "seq r55F45");
        for (int j = 0; j < DEPTH - PRE - 1; j++) begin
            cyc(0, 8'(j), (j < DEPTH - PRE - 2), 0, (j == DEPTH - PRE - 2), "seq post");
        end

        // ---- arm from DONE, completion on last FILL cycle ignored
        cyc(1, 8'd9, 1, 0, 0, "arm from done");
        cyc(0, 8'd9, 1, 0, 0, "late fill0");
        cyc(0, 8'd5, 1, 0, 0, "late fill1");
        cyc(0, 8'd4, 1, 0, 0, "late fill2");
        cyc(0, 8'd5, 1, 0, 0, "late fill3");
        cyc(0, 8'd4, 1, 0, 0, "late armed4");
        cyc(0, 8'd5, 1, 0, 0, "late armed5");
        cyc(0, 8'd4, 1, 0, 0, "late armed4b");
        // ---- re-arm while ARMED: pre-count reloaded
        cyc(1, 8'd9, 1, 0, 0, "rearm armed");
        cyc(0, 8'd5, 1, 0, 0, "reload fill5");
        cyc(0, 8'd4, 1, 0, 0, "reload fill4");
        cyc(0, 8'd5, 1, 0, 0, "reload fill5b");
        cyc(0, 8'd1, 1, 0, 0, "reload fill1");
        cyc(0, 8'd5, 1, 0, 0, "reload a5");
        cyc(0, 8'd4, 1, 0, 0, "reload a4");
        cyc(0, 8'd5, 1, 1, 0, "reload trig");
        for (int j = 0; j < 3; j++) cyc(0, 8'(j), 1, 0, 0, "pre-reset post");

        // ---- asynchronous reset mid-POST
        #2 _rst = 1'b0;
        #1;
        chk("mid rst run",   32'(o_run),       32'd0);
        chk("mid rst avail", 32'(o_available), 32'd0);
        chk("mid rst trig",  32'(o_triggered), 32'd0);
        chk("mid rst data",  o_data,           32'd0);
        #4 _rst = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cyc(0, (j % 3 == 1) ? 8'd4 : 8'd5, 0, 0, 0, "after rst");
        end

        // ---- randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < STAGES; k++) begin
                mv[k] = 8'($urandom);
                mm[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            end
            set_stages(mv[0], mv[1], mv[2], mm[0], mm[1], mm[2]);
            i_btn = 1'b0;
            tick();
            i_btn  = 1'b1;
            i_data = 8'($urandom);
            i_read = 1'($urandom);
            tick();
            chk("rand arm run", 32'(o_run), 32'd1);
            i_btn = 1'b0;

            wr.delete();
            phase = 0;
            pcnt  = 0;
            s     = 0;
            guard = 0;
            while (phase != 3 && guard < 400) begin
                if (phase == 1 && pcnt > 60)          d = mv[s];
                else if ($urandom_range(0, 3) != 0)   d = mv[$urandom_range(0, STAGES - 1)];
                else                                  d = 8'($urandom);
                wr.push_back(d);
                trig_now = 1'b0;
                case (phase)
                    0: begin
                        pcnt++;
                        if (pcnt == PRE) begin phase = 1; pcnt = 0; end
                    end
                    1: begin
                        pcnt++;
                        if (hit(d, s)) begin
                            if (s == STAGES - 1) begin
                                trig_now = 1'b1;
                                phase = 2;
                                pcnt  = 0;
                                s     = 0;
                            end else begin
                                s++;
                            end
                        end else begin
                            s = hit(d, 0) ? 1 : 0;
                        end
                    end
                    default: begin
                        pcnt++;
                        if (pcnt == DEPTH - PRE - 1) phase = 3;
                    end
                endcase
                i_data = d;
                i_read = 1'($urandom);
                tick();
                chk($sformatf("rand%0d trig", r),  32'(o_triggered), 32'(trig_now));
                chk($sformatf("rand%0d run", r),   32'(o_run),       32'(phase != 3));
                chk($sformatf("rand%0d avail", r), 32'(o_available), 32'(phase == 3));
                guard++;
            end
            chk($sformatf("rand%0d done", r), 32'(phase), 32'd3);

            idx   = 0;
            guard = 0;
            while (phase == 3 && idx < DEPTH && guard < 200) begin
                chk($sformatf("rand%0d rd avail", r), 32'(o_available), 32'd1);
                chk($sformatf("rand%0d word %0d", r, idx), o_data,
                    word(idx, wr[wr.size() - DEPTH + idx]));
                rd     = 1'($urandom);
                i_read = rd;
                tick();
                if (rd) idx++;
                guard++;
            end
            i_read = 1'b0;
            chk($sformatf("rand%0d read count", r), 32'(idx), 32'(DEPTH));
            chk($sformatf("rand%0d end avail", r), 32'(o_available), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
